// File: rtl/sc_imem_arbiter.sv
// sc_imem_arbiter: shares the single-cycle core's combinational instruction ROM between
// CPU fetch (port F) and debug/trace readback (port D). Fetch has fixed priority; a
// starvation counter force-grants debug after STARVE_MAX consecutive denied cycles.
// Read data is registered, giving each requester a one-cycle request/response handshake.
// Optional feature: define IMEM_ARB_ALIGN_CHK_EN to add f_err/d_err, which flag responses
// to misaligned addresses; such responses carry a nop instead of the ROM word.
module sc_imem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
`ifdef IMEM_ARB_ALIGN_CHK_EN
    output logic          f_err,
    output logic          d_err,
`endif
    output logic [AW-1:0] mem_a,
    input  logic [31:0]   mem_inst,
    output logic [3:0]    starve_cnt
);

    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);
    // Keeps byte-offset and word-index bits; higher bits wrap onto the ROM.
    localparam logic [AW-1:0] ADDR_MASK  = {AW{1'b1}} >> (AW - IDX_W - 2);

    typedef enum logic [1:0] {OwnNone, OwnF, OwnD} owner_e;

    owner_e         owner_q, owner_d;
    logic [3:0]     starve_q, starve_d;
    logic [31:0]    f_rdata_q, d_rdata_q;
    logic [31:0]    rdata_in;
    logic [AW-1:0]  sel_addr;
    logic           force_d;

    // Grant decision and memory address mux; no grants while in reset.
    always_comb begin
        force_d = d_req & (starve_q >= STARVE_LIM);
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        if (!rst) begin
            if (force_d) begin
                d_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
        sel_addr = d_gnt ? d_addr : f_addr;
        mem_a    = sel_addr & ADDR_MASK;
    end

    // Starvation count: counts denied debug cycles, saturating at 15.
    always_comb begin
        if (d_gnt || !d_req) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

`ifdef IMEM_ARB_ALIGN_CHK_EN
    logic misalign;
    logic f_err_q, d_err_q;

    // Misaligned accesses return a nop in place of the ROM word.
    always_comb begin
        misalign = |sel_addr[1:0];
        rdata_in = misalign ? 32'h0000_0013 : mem_inst;
    end

    // Error flags live for exactly the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            f_err_q <= f_gnt & misalign;
            d_err_q <= d_gnt & misalign;
        end
    end

    assign f_err = f_err_q;
    assign d_err = d_err_q;
`else
    assign rdata_in = mem_inst;
`endif

    // Owner state register: which port was granted on the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OwnNone;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Owner next state: follows this cycle's grant, NONE when idle.
    always_comb begin
        owner_d = OwnNone;
        if (f_gnt) begin
            owner_d = OwnF;
        end else if (d_gnt) begin
            owner_d = OwnD;
        end
    end

    // Owner outputs: route the response valid to the previous grantee.
    always_comb begin
        f_rvalid = 1'b0;
        d_rvalid = 1'b0;
        unique case (owner_q)
            OwnF:    f_rvalid = 1'b1;
            OwnD:    d_rvalid = 1'b1;
            default: ;
        endcase
    end

    // Read data capture at the grant edge plus starvation count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            starve_q  <= 4'd0;
        end else begin
            starve_q <= starve_d;
            if (f_gnt) begin
                f_rdata_q <= rdata_in;
            end
            if (d_gnt) begin
                d_rdata_q <= rdata_in;
            end
        end
    end

    assign f_rdata    = f_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_sc_imem_arbiter.sv
// Bench for sc_imem_arbiter: directed literal checks plus randomized traffic checked every
// cycle against a behavioural model of the arbitration and response rules.
module tb_sc_imem_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req;
    logic [31:0] f_addr, d_addr;
    logic        f_gnt, d_gnt, f_rvalid, d_rvalid;
    logic [31:0] f_rdata, d_rdata;
    logic [31:0] mem_a, mem_inst;
    logic [3:0]  starve_cnt;
`ifdef IMEM_ARB_ALIGN_CHK_EN
    logic        f_err, d_err;
`endif

    logic [31:0] rom [0:31];
    assign mem_inst = rom[mem_a[6:2]];

    always #5 clk = ~clk;

    sc_imem_arbiter #(
        .AW         (32),
        .IDX_W      (5),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
`ifdef IMEM_ARB_ALIGN_CHK_EN
        .f_err      (f_err),
        .d_err      (d_err),
`endif
        .mem_a      (mem_a),
        .mem_inst   (mem_inst),
        .starve_cnt (starve_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Word a requester should receive for a byte address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
`ifdef IMEM_ARB_ALIGN_CHK_EN
        if (a[1:0] != 2'b00) return 32'h0000_0013;
`endif
        return rom[a[6:2]];
    endfunction

    // Model state: what each port's outputs must show this cycle.
    logic        chk_en = 1'b0;
    logic        m_fv = 1'b0, m_dv = 1'b0, m_fe = 1'b0, m_de = 1'b0;
    logic [31:0] m_fd = '0, m_dd = '0;
    int          m_starve = 0;
    logic        m_fg = 1'b0, m_dg = 1'b0;

    // Compare process: checks every cycle at the falling edge, then advances the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic eg_f, eg_d;
            eg_f = 1'b0;
            eg_d = 1'b0;
            if (!rst) begin
                if (d_req && m_starve >= STARVE_MAX) eg_d = 1'b1;
                else if (f_req)                      eg_f = 1'b1;
                else if (d_req)                      eg_d = 1'b1;
            end
            chk("f_gnt", {31'd0, f_gnt}, {31'd0, eg_f});
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, eg_d});
            chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, m_fv});
            chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_dv});
            chk("f_rdata", f_rdata, m_fd);
            chk("d_rdata", d_rdata, m_dd);
            chk("starve_cnt", {28'd0, starve_cnt}, m_starve);
            chk("mem_a_idx", {27'd0, mem_a[6:2]}, {27'd0, eg_d ? d_addr[6:2] : f_addr[6:2]});
`ifdef IMEM_ARB_ALIGN_CHK_EN
            chk("f_err", {31'd0, f_err}, {31'd0, m_fe});
            chk("d_err", {31'd0, d_err}, {31'd0, m_de});
`endif
            m_fg = eg_f;
            m_dg = eg_d;
            if (rst) begin
                m_fv = 1'b0; m_dv = 1'b0; m_fe = 1'b0; m_de = 1'b0;
                m_fd = '0;   m_dd = '0;   m_starve = 0;
            end else begin
                m_fv = eg_f;
                m_dv = eg_d;
                m_fe = eg_f && (f_addr[1:0] != 2'b00);
                m_de = eg_d && (d_addr[1:0] != 2'b00);
                if (eg_f) m_fd = word_at(f_addr);
                if (eg_d) m_dd = word_at(d_addr);
                if (d_req && !eg_d) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
                else                m_starve = 0;
            end
        end
    end

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
`ifdef IMEM_ARB_ALIGN_CHK_EN
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`endif
        return a;
    endfunction

    initial begin
        logic [31:0] stream_exp [0:2];
        stream_exp[0] = 32'h0000_00B7;
        stream_exp[1] = 32'h0500_E213;
        stream_exp[2] = 32'h0040_0293;
        rom[0] = 32'h0000_00B7;
        rom[1] = 32'h0500_E213;
        rom[2] = 32'h0040_0293;
        rom[3] = 32'h0580_00EF;
        for (int i = 4; i < 32; i++) rom[i] = $urandom;

        // Reset with a fetch request pending: no grant may appear.
        rst = 1'b1; f_req = 1'b1; f_addr = 32'h4; d_req = 1'b0; d_addr = 32'h0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        mid();
        chk("gnt_in_reset", {30'd0, f_gnt, d_gnt}, 32'd0);
        nxt();
        chk("reset_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
        chk("reset_rdata", f_rdata | d_rdata, 32'd0);
        chk("reset_starve", {28'd0, starve_cnt}, 32'd0);

        // Single fetch of 0x04.
        rst = 1'b0; f_req = 1'b1; f_addr = 32'h4;
        mid();
        chk("t1_f_gnt", {31'd0, f_gnt}, 32'd1);
        nxt();
        f_req = 1'b0;
        mid();
        chk("t1_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("t1_f_rdata", f_rdata, 32'h0500_E213);
        chk("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        nxt();

        // Back-to-back fetch stream 0x00, 0x04, 0x08.
        for (int i = 0; i < 4; i++) begin
            f_req  = (i < 3);
            f_addr = 32'(i * 4);
            mid();
            if (i > 0) begin
                chk("stream_rvalid", {31'd0, f_rvalid}, 32'd1);
                chk("stream_rdata", f_rdata, stream_exp[i-1]);
            end
            nxt();
        end

        // Continuous fetch starves debug until the force grant.
        for (int k = 0; k < 5; k++) begin
            f_req = 1'b1; d_req = 1'b1; d_addr = 32'hC;
            mid();
            chk("starve_cnt_ramp", {28'd0, starve_cnt}, 32'(k));
            chk("starve_d_gnt", {31'd0, d_gnt}, (k == 4) ? 32'd1 : 32'd0);
            chk("starve_f_gnt", {31'd0, f_gnt}, (k == 4) ? 32'd0 : 32'd1);
            nxt();
        end
        d_req = 1'b0;
        mid();
        chk("force_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("force_d_rdata", d_rdata, 32'h0580_00EF);
        chk("force_starve_clr", {28'd0, starve_cnt}, 32'd0);
        nxt();
        f_req = 1'b0;
        nxt();

        // Idle fetch: debug granted at once, high address bits wrap.
        d_req = 1'b1; d_addr = 32'h84;
        mid();
        chk("wrap_d_gnt", {31'd0, d_gnt}, 32'd1);
        nxt();
        d_req = 1'b0;
        mid();
        chk("wrap_d_rdata", d_rdata, 32'h0500_E213);
        nxt();

`ifdef IMEM_ARB_ALIGN_CHK_EN
        d_req = 1'b1; d_addr = 32'h6;
        nxt();
        d_addr = 32'h4;
        mid();
        chk("align_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("align_d_err", {31'd0, d_err}, 32'd1);
        chk("align_d_rdata", d_rdata, 32'h0000_0013);
        nxt();
        d_req = 1'b0;
        mid();
        chk("align_ok_err", {31'd0, d_err}, 32'd0);
        chk("align_ok_rdata", d_rdata, 32'h0500_E213);
        nxt();
`endif

        // Request coinciding with reset: no response, data cleared.
        rst = 1'b1; f_req = 1'b1; f_addr = 32'h10;
        mid();
        chk("rst_req_f_gnt", {31'd0, f_gnt}, 32'd0);
        nxt();
        rst = 1'b0; f_req = 1'b0;
        mid();
        chk("rst_req_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rst_req_rdata", f_rdata, 32'd0);
        nxt();

        // Randomized traffic; requesters hold req/addr until the model says granted.
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!f_req || m_fg) begin
                f_req  = ($urandom_range(0, 9) < 8);
                f_addr = rnd_addr();
            end
            if (!d_req || m_dg) begin
                d_req  = ($urandom_range(0, 1) == 1);
                d_addr = rnd_addr();
            end
            nxt();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
